piso_tx_arbiter: RTL

- Two-requester serial transmit controller. Arbitrates between two parallel-word sources and sequences an internal parallel-in/serial-out shift register and bit counter.
- Emits framed serial output: start bit, WIDTH data bits LSB-first, optional parity bit, stop bit.
- Sits between local parallel producers and a single shared serial line.

---
 rtl/piso_tx_if.sv | 25 ++
 rtl/piso_tx_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/piso_tx_if.sv
// Handshake and serial-line bundle for piso_tx_arbiter: two parallel requesters in, one framed serial line out.
interface piso_tx_if #(
  parameter int WIDTH = 4
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_data;
  logic             req1_ready;
  logic             tx_q;
  logic             busy;
  logic             grant_id;
  logic             done;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready, tx_q, busy, grant_id, done
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready, tx_q, busy, grant_id, done
  );
endinterface

// File: rtl/piso_tx_arbiter.sv
// Round-robin two-requester serial transmitter: start bit, WIDTH data bits LSB-first, stop bit.
// Define PISO_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module piso_tx_arbiter #(
  parameter int WIDTH    = 4,
  parameter int BAUD_DIV = 1
) (
  input  logic     clk,
  input  logic     reset,
  piso_tx_if.slave bus
);

  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int CW = $clog2(WIDTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
`ifdef PISO_TX_PARITY_EN
    S_PAR   = 3'd3,
`endif
    S_STOP  = 3'd4
  } state_t;

  state_t           state, state_n;
  logic [BW-1:0]    baud_cnt, baud_n;
  logic [CW-1:0]    bit_cnt, bit_n;
  logic [WIDTH-1:0] shift, shift_n;
  logic             last_grant, last_n;
  logic             grant, grant_n;
  logic             tx, tx_n;
  logic             busy_r, busy_n;
  logic             done_r, done_n;
  logic             rdy0, rdy1;
  logic             bit_end;
`ifdef PISO_TX_PARITY_EN
  logic             par_bit, par_n;
`endif

  // Ready is combinational and only offered from IDLE; ties go to whoever did not win last.
  always_comb begin
    rdy0 = 1'b0;
    rdy1 = 1'b0;
    if (state == S_IDLE && !reset) begin
      if (bus.req0_valid && (!bus.req1_valid || last_grant)) rdy0 = 1'b1;
      else if (bus.req1_valid)                               rdy1 = 1'b1;
    end
  end

  assign bit_end = (baud_cnt == BAUD_LAST);

  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_cnt;
    shift_n = shift;
    grant_n = grant;
    last_n  = last_grant;
`ifdef PISO_TX_PARITY_EN
    par_n   = par_bit;
`endif
    case (state)
      S_IDLE: begin
        baud_n = '0;
        bit_n  = '0;
        if (rdy0) begin
          shift_n = bus.req0_data;
          grant_n = 1'b0;
          last_n  = 1'b0;
          state_n = S_START;
`ifdef PISO_TX_PARITY_EN
          par_n   = ^bus.req0_data;
`endif
        end else if (rdy1) begin
          shift_n = bus.req1_data;
          grant_n = 1'b1;
          last_n  = 1'b1;
          state_n = S_START;
`ifdef PISO_TX_PARITY_EN
          par_n   = ^bus.req1_data;
`endif
        end
      end
      S_START: begin
        if (bit_end) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = S_DATA;
        end else begin
          baud_n = baud_cnt + BW'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_n  = '0;
          shift_n = shift >> 1;
          if (bit_cnt == BIT_LAST) begin
`ifdef PISO_TX_PARITY_EN
            state_n = S_PAR;
`else
            state_n = S_STOP;
`endif
          end else begin
            bit_n = bit_cnt + CW'(1);
          end
        end else begin
          baud_n = baud_cnt + BW'(1);
        end
      end
`ifdef PISO_TX_PARITY_EN
      S_PAR: begin
        if (bit_end) begin
          baud_n  = '0;
          state_n = S_STOP;
        end else begin
          baud_n = baud_cnt + BW'(1);
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          baud_n  = '0;
          state_n = S_IDLE;
        end else begin
          baud_n = baud_cnt + BW'(1);
        end
      end
      default: begin
        state_n = S_IDLE;
        baud_n  = '0;
        bit_n   = '0;
      end
    endcase
  end

  // Line outputs are decoded from next-state values so they are plain flops aligned to state.
  always_comb begin
    tx_n = 1'b1;
    case (state_n)
      S_START: tx_n = 1'b0;
      S_DATA:  tx_n = shift_n[0];
`ifdef PISO_TX_PARITY_EN
      S_PAR:   tx_n = par_n;
`endif
      default: tx_n = 1'b1;
    endcase
    busy_n = (state_n != S_IDLE);
    done_n = (state_n == S_STOP) && (baud_n == BAUD_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      tx         <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
`ifdef PISO_TX_PARITY_EN
      par_bit    <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      baud_cnt   <= baud_n;
      bit_cnt    <= bit_n;
      shift      <= shift_n;
      grant      <= grant_n;
      last_grant <= last_n;
      tx         <= tx_n;
      busy_r     <= busy_n;
      done_r     <= done_n;
`ifdef PISO_TX_PARITY_EN
      par_bit    <= par_n;
`endif
    end
  end

  assign bus.req0_ready = rdy0;
  assign bus.req1_ready = rdy1;
  assign bus.tx_q       = tx;
  assign bus.busy       = busy_r;
  assign bus.grant_id   = grant;
  assign bus.done       = done_r;

endmodule
